// File: rtl/bresenham_line_drawer.sv
// Rasterizes one line segment into a stream of single-pixel framebuffer writes,
// one pixel per clock, using integer Bresenham stepping in all eight octants.
//
// state | meaning
// IDLE  | waiting for start, endpoints and color latched on acceptance
// SETUP | derive deltas, step directions and initial error term
// DRAW  | present one pixel per cycle and step toward the end point
// DONE  | one-cycle done pulse, then back to IDLE
module bresenham_line_drawer #(
  parameter int WIDTH = 11,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             color_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             pixel_color,
  output logic             pixel_write
);

  localparam int EW = WIDTH + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [EW:0]   e2;
  logic signed [EW-1:0] xa, xb, ya, yb;
  logic sx_q, sx_d, sy_q, sy_d;
  logic color_q, color_d, pw_q, pw_d, busy_q, busy_d, done_q, done_d;

  function automatic logic in_range(input logic [WIDTH-1:0] px, input logic [WIDTH-1:0] py);
    return (int'(px) < X_MAX) && (int'(py) < Y_MAX);
  endfunction

  assign xa = $signed({3'b000, x0_q});
  assign xb = $signed({3'b000, x1_q});
  assign ya = $signed({3'b000, y0_q});
  assign yb = $signed({3'b000, y1_q});
  assign e2 = $signed({err_q, 1'b0});

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    color_d = color_q;
    pw_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          color_d = color_in;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // dy is kept negative so the classic single-error-term form works in every octant
        sx_d    = (x0_q < x1_q);
        sy_d    = (y0_q < y1_q);
        dx_d    = (xb > xa) ? (xb - xa) : (xa - xb);
        dy_d    = (yb > ya) ? (ya - yb) : (yb - ya);
        err_d   = dx_d + dy_d;
        x_d     = x0_q;
        y_d     = y0_q;
        pw_d    = in_range(x0_q, y0_q);
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if ((x_q == x1_q) && (y_q == y1_q)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          if (e2 >= dy_q) begin
            err_d = err_d + dy_q;
            x_d   = sx_q ? (x_q + 1'b1) : (x_q - 1'b1);
          end
          if (e2 <= dx_q) begin
            err_d = err_d + dx_q;
            y_d   = sy_q ? (y_q + 1'b1) : (y_q - 1'b1);
          end
          pw_d = in_range(x_d, y_d);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      color_q <= 1'b0;
      pw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      color_q <= color_d;
      pw_q    <= pw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_color = color_q;
  assign pixel_write = pw_q;

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Self-checking bench: directed and random lines compared against a software
// Bresenham rasterizer, plus handshake and mid-line reset behaviour.
module tb_bresenham_line_drawer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] x0, y0, x1, y1;
  logic        color_in;
  logic        busy, done, pixel_color, pixel_write;
  logic [10:0] x, y;

  int checks = 0;
  int errors = 0;
  int px[$];
  int py[$];

  bresenham_line_drawer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
    .busy(busy), .done(done), .x(x), .y(y),
    .pixel_color(pixel_color), .pixel_write(pixel_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rasterizer: list of pixel coordinates from start to end point.
  task automatic build_model(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, cx, cy;
    px.delete();
    py.delete();
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = (by > ay) ? ay - by : by - ay;
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx + dy;
    cx  = ax;
    cy  = ay;
    forever begin
      px.push_back(cx);
      py.push_back(cy);
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  task automatic scramble_inputs();
    x0 = 11'($urandom_range(0, 2047));
    y0 = 11'($urandom_range(0, 2047));
    x1 = 11'($urandom_range(0, 2047));
    y1 = 11'($urandom_range(0, 2047));
    color_in = 1'($urandom_range(0, 1));
  endtask

  task automatic run_line(input int ax, input int ay, input int bx, input int by,
                          input bit c, input int pulse_at, input bit start_in_done);
    int n;
    build_model(ax, ay, bx, by);
    n = px.size();
    @(negedge clk);
    x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
    color_in = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_pw", 32'(pixel_write), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("pix_x", 32'(x), 32'(px[i]));
      chk("pix_y", 32'(y), 32'(py[i]));
      chk("pix_write", 32'(pixel_write), 32'((px[i] < 640) && (py[i] < 480)));
      chk("pix_color", 32'(pixel_color), 32'(c));
      chk("draw_busy", 32'(busy), 32'd1);
      chk("draw_done", 32'(done), 32'd0);
      start = (i == pulse_at);
      if (i == pulse_at) scramble_inputs();
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_pw", 32'(pixel_write), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pw", 32'(pixel_write), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    color_in = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pw", 32'(pixel_write), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_color", 32'(pixel_color), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_line(0, 0, 5, 0, 1'b1, -1, 1'b0);
    run_line(10, 4, 0, 0, 1'b0, -1, 1'b0);
    run_line(3, 0, 5, 9, 1'b1, -1, 1'b0);
    run_line(7, 7, 7, 7, 1'b1, -1, 1'b1);
    run_line(630, 479, 645, 479, 1'b1, -1, 1'b0);
    run_line(20, 30, 60, 5, 1'b1, 10, 1'b0);

    // Mid-line reset: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    x0 = 11'd100; y0 = 11'd100; x1 = 11'd200; y1 = 11'd150;
    color_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_pw", 32'(pixel_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pw", 32'(pixel_write), 32'd0);
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_color", 32'(pixel_color), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_pw", 32'(pixel_write), 32'd0);
    run_line(50, 60, 40, 90, 1'b1, -1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      int lim;
      int pa;
      lim = (k % 8 == 7) ? 2047 : 700;
      pa  = (k % 3 == 0) ? int'($urandom_range(0, 3)) : -1;
      run_line(int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
               int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
               1'($urandom_range(0, 1)), pa, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bresenham_line_drawer.md
# bresenham_line_drawer

Rasterizes one line segment between two endpoints into a stream of single-pixel writes, one pixel per clock, using integer Bresenham stepping across all eight octants. It sits directly upstream of `VGA_framebuffer`: `line_animator` issues endpoint pairs and a color, and this block drives the framebuffer's `x`, `y`, `pixel_color` and `pixel_write` inputs. A start/busy/done handshake lets the animator sequence erase and draw passes.

## Interface
- `WIDTH`, 11: coordinate width in bits.
- `X_MAX`, 640: horizontal resolution; pixels with x ≥ X_MAX are suppressed.
- `Y_MAX`, 480: vertical resolution; pixels with y ≥ Y_MAX are suppressed.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset_n`  in  1  **asynchronous, active-low reset**.
- `start`  in  1  request a new line; sampled only in IDLE.
- `x0`, `y0`  in  WIDTH  start point, unsigned.
- `x1`, `y1`  in  WIDTH  end point, unsigned.
- `color_in`  in  1  color for every pixel of this line.
- `busy`  out  1  high from the cycle after accepted `start` until DONE exits.
- `done`  out  1  single-cycle pulse after the last pixel.
- `x`, `y`  out  WIDTH  current pixel address.
- `pixel_color`  out  1  latched `color_in`.
- `pixel_write`  out  1  high when (`x`,`y`) is a valid, in-range pixel.

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: `busy`=0 and `pixel_write`=0. On `start`=1, latch `x0`..`y1` and `color_in`, then go to SETUP.
- SETUP (1 cycle):
  - dx = |x1−x0|; dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1; sy = +1 if y0<y1, else −1.
  - err = dx+dy; cur = (x0,y0).
  - Go to DRAW.
- DRAW, one pixel per cycle:
  - Present `x`,`y` = cur and `pixel_write`=1 unless cur.x ≥ X_MAX or cur.y ≥ Y_MAX.
  - If cur == (x1,y1), go to DONE.
  - Otherwise compute e2 = 2·err. If e2 ≥ dy: err += dy and x += sx. If e2 ≤ dx: err += dx and y += sy. Both updates may happen in the same cycle, using the pre-update err.
- DONE (1 cycle): `done`=1, `pixel_write`=0, then return to IDLE.
- Arithmetic: dx, dy and err are signed WIDTH+3 bits, so no overflow occurs for any 11-bit endpoints. Coordinate steps use WIDTH-bit arithmetic and never wrap, because stepping stops at the endpoint.
- Pixel count per line = max(dx, |dy|) + 1. A degenerate line (x0=x1, y0=y1) emits exactly 1 pixel.
- `start` while busy is ignored. Input changes after acceptance have no effect.
- `start` held high in the DONE cycle is not accepted. It is sampled on the following IDLE cycle, which gives a minimum 1 idle cycle between lines.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `pixel_write`=0, `x`=0, `y`=0, `pixel_color`=0. Reset acts immediately, including mid-line. No partial pixels are emitted after deassertion.
- `start` sampled at edge T → SETUP during T+1 → first pixel valid during T+2.
- An N-pixel line occupies DRAW for cycles T+2..T+N+1, with `done` high at T+N+2.
- All outputs are registered; no combinational path from inputs to outputs.
- `pixel_write` is never high in IDLE, SETUP or DONE.

## Test plan
- Horizontal line: (0,0)→(5,0), color 1, start at T → pixels x=0..5, y=0 at T+2..T+7 with `pixel_write`=1. `done` at T+8 and `busy` low at T+9.
- Reverse shallow line: (10,4)→(0,0) → 11 pixels, x decrements by 1 every cycle, y from 4 down to 0, ends exactly at (0,0). Sequence matches a software Bresenham model.
- Steep line: (3,0)→(5,9) → 10 pixels, y increments every cycle, x steps 3→5 monotonically, last pixel (5,9).
- Single point: (7,7)→(7,7) → exactly 1 pixel at T+2, `done` at T+3.
- Clipping: (630,479)→(645,479) → 16 DRAW cycles. `pixel_write`=1 only for x=630..639, 0 for x=640..645. `done` still fires.
- Handshake and reset:
  - Pulse `start` again mid-line → ignored; pixel sequence unchanged.
  - Assert `reset_n`=0 mid-DRAW → all outputs 0 immediately and state returns to IDLE.
  - Deassert, then start a new line → it runs correctly from SETUP.
